uart_tx_buffer: RTL and testbench

//  Byte FIFO directly upstream of the UART transmitter. Decouples a bursty byte producer
//  (CPU/bus write strobe) from the 115200-baud serial engine. Drives the UART's
//  tx_req/tx_byte and consumes its one-cycle tx_ack pulse, popping one byte per ack.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo_mem.sv | 24 ++
 rtl/uart_tx_buffer.sv | 119 +++++++++++
 tb/tb_uart_tx_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte width, default FIFO geometry and transmit FSM encoding
package uart_pkg;

   localparam int UART_BYTE_W    = 8;
   localparam int DEFAULT_DEPTH  = 16;
   localparam int DEFAULT_ADDR_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - DEPTH x byte storage, synchronous write, asynchronous read
module uart_tx_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic                   Clk,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      waddr,
   input  logic [UART_BYTE_W-1:0] wdata,
   input  logic [ADDR_W-1:0]      raddr,
   output logic [UART_BYTE_W-1:0] rdata
);

   logic [UART_BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge Clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO feeding the UART transmitter; UART_TX_BUFFER_OVF_EN adds a sticky overflow flag
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic                   Clk,
   input  logic                   nReset,
   input  logic                   wr_en,
   input  logic [UART_BYTE_W-1:0] wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [ADDR_W:0]        level,
   output logic [UART_BYTE_W-1:0] tx_byte,
   output logic                   tx_req,
   input  logic                   tx_ack,
   output logic                   ovf,
   input  logic                   ovf_clr
);

   localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

   tx_state_t              state;
   logic [ADDR_W-1:0]      wp;
   logic [ADDR_W-1:0]      rp;
   logic [ADDR_W:0]        level_next;
   logic [UART_BYTE_W-1:0] rd_data;
   logic [UART_BYTE_W-1:0] head;
   logic                   push;
   logic                   pop;

   assign push = wr_en & ~full;
   assign pop  = (state == ST_REQ) & tx_ack;
   // An empty FIFO forwards the incoming byte so tx_req rises the cycle after the write.
   assign head = empty ? wr_data : rd_data;

   uart_tx_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .Clk   (Clk),
      .we    (push),
      .waddr (wp),
      .wdata (wr_data),
      .raddr (rp),
      .rdata (rd_data)
   );

   always_comb begin
      level_next = level;
      if (push && !pop)      level_next = level + (ADDR_W+1)'(1);
      else if (pop && !push) level_next = level - (ADDR_W+1)'(1);
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         if (push) wp <= wp + ADDR_W'(1);
         if (pop)  rp <= rp + ADDR_W'(1);
         level <= level_next;
         empty <= (level_next == '0);
         full  <= (level_next == LEVEL_FULL);
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state   <= ST_IDLE;
         tx_req  <= 1'b0;
         tx_byte <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty || push) begin
                  state   <= ST_REQ;
                  tx_req  <= 1'b1;
                  tx_byte <= head;
               end
            end
            ST_REQ: begin
               if (tx_ack) begin
                  state  <= ST_GAP;
                  tx_req <= 1'b0;
               end
            end
            ST_GAP: begin
               // empty already reflects the pop taken on entry to GAP
               if (!empty) begin
                  state   <= ST_REQ;
                  tx_req  <= 1'b1;
                  tx_byte <= rd_data;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state  <= ST_IDLE;
               tx_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef UART_TX_BUFFER_OVF_EN
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset)            ovf <= 1'b0;
      else if (wr_en && full) ovf <= 1'b1;
      else if (ovf_clr)       ovf <= 1'b0;
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - directed self-checking bench for uart_tx_buffer with a UART transmitter model
module tb_uart_tx_buffer;

   localparam int DEPTH     = 16;
   localparam int ADDR_W    = 4;
   localparam int UART_BUSY = 40;
`ifdef UART_TX_BUFFER_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic             Clk = 1'b0;
   logic             nReset;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             full;
   logic             empty;
   logic [ADDR_W:0]  level;
   logic [7:0]       tx_byte;
   logic             tx_req;
   logic             tx_ack;
   logic             ovf;
   logic             ovf_clr;

   int         checks   = 0;
   int         failures = 0;
   int         busy;
   int         gap_err;
   bit         gap_pending;
   bit         gap_follow;
   logic [7:0] rx_q [$];

   uart_tx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .Clk     (Clk),
      .nReset  (nReset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .level   (level),
      .tx_byte (tx_byte),
      .tx_req  (tx_req),
      .tx_ack  (tx_ack),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   always #20 Clk = ~Clk;

   task automatic model_reset();
      tx_ack      = 1'b0;
      busy        = 0;
      gap_err     = 0;
      gap_pending = 1'b0;
      rx_q.delete();
   endtask

   // One negedge step of the UART: latch and ack a pending byte, then stay busy.
   task automatic model_step(output bit acking);
      acking = 1'b0;
      if (tx_ack) begin
         tx_ack = 1'b0;
         busy   = UART_BUSY;
         if (tx_req !== 1'b0) gap_err++;
         gap_follow  = (level != '0);
         gap_pending = 1'b1;
      end else begin
         if (gap_pending) begin
            if (tx_req !== gap_follow) gap_err++;
            gap_pending = 1'b0;
         end
         if (busy > 0) busy--;
         else if (tx_req === 1'b1) begin
            rx_q.push_back(tx_byte);
            tx_ack = 1'b1;
            acking = 1'b1;
         end
      end
   endtask

   task automatic uart_drain(input int n, input int limit);
      bit a;
      int cyc = 0;
      while ((rx_q.size() < n || tx_ack || gap_pending) && cyc < limit) begin
         model_step(a);
         @(negedge Clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      nReset = 1'b0; wr_en = 1'b0; wr_data = '0; tx_ack = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge Clk);
      checks++; if (level !== 5'd0)   begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
      checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0)    begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
      checks++; if (tx_req !== 1'b0)  begin failures++; $display("FAIL rst_tx_req got=%b exp=0", tx_req); end
      checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL rst_tx_byte got=%h exp=00", tx_byte); end
      checks++; if (ovf !== 1'b0)     begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
      nReset = 1'b1;
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
         @(negedge Clk);
      end
      wr_en = 1'b0;
      checks++; if (tx_req !== 1'b1)  begin failures++; $display("FAIL midreq_pre_tx_req got=%b exp=1", tx_req); end
      checks++; if (level !== 5'd3)   begin failures++; $display("FAIL midreq_pre_level got=%0d exp=3", level); end
      nReset = 1'b0;
      #1;
      checks++; if (tx_req !== 1'b0)  begin failures++; $display("FAIL midreq_rst_tx_req got=%b exp=0", tx_req); end
      checks++; if (level !== 5'd0)   begin failures++; $display("FAIL midreq_rst_level got=%0d exp=0", level); end
      checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL midreq_rst_empty got=%b exp=1", empty); end
      @(negedge Clk);
      nReset = 1'b1;
      repeat (2) @(negedge Clk);
      checks++; if (tx_req !== 1'b0)  begin failures++; $display("FAIL midreq_post_tx_req got=%b exp=0", tx_req); end
   endtask

   task automatic test_single();
      model_reset();
      wr_en = 1'b1; wr_data = 8'h41;
      @(negedge Clk);
      wr_en = 1'b0;
      checks++; if (tx_req !== 1'b1)   begin failures++; $display("FAIL single_tx_req got=%b exp=1", tx_req); end
      checks++; if (tx_byte !== 8'h41) begin failures++; $display("FAIL single_tx_byte got=%h exp=41", tx_byte); end
      checks++; if (level !== 5'd1)    begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
      tx_ack = 1'b1;
      @(negedge Clk);
      tx_ack = 1'b0;
      checks++; if (tx_req !== 1'b0)   begin failures++; $display("FAIL single_gap_tx_req got=%b exp=0", tx_req); end
      checks++; if (level !== 5'd0)    begin failures++; $display("FAIL single_pop_level got=%0d exp=0", level); end
      checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
      @(negedge Clk);
      checks++; if (tx_req !== 1'b0)   begin failures++; $display("FAIL single_idle_tx_req got=%b exp=0", tx_req); end
   endtask

   task automatic test_spurious();
      tx_ack = 1'b1;
      @(negedge Clk);
      tx_ack = 1'b0;
      checks++; if (level !== 5'd0)    begin failures++; $display("FAIL idle_ack_level got=%0d exp=0", level); end
      checks++; if (tx_req !== 1'b0)   begin failures++; $display("FAIL idle_ack_tx_req got=%b exp=0", tx_req); end
      wr_en = 1'b1; wr_data = 8'h51;
      @(negedge Clk);
      wr_data = 8'h52;
      @(negedge Clk);
      wr_en = 1'b0;
      checks++; if (tx_byte !== 8'h51) begin failures++; $display("FAIL spur_first_byte got=%h exp=51", tx_byte); end
      tx_ack = 1'b1;
      @(negedge Clk);
      checks++; if (level !== 5'd1)    begin failures++; $display("FAIL spur_pop_level got=%0d exp=1", level); end
      @(negedge Clk);
      tx_ack = 1'b0;
      checks++; if (level !== 5'd1)    begin failures++; $display("FAIL gap_ack_level got=%0d exp=1", level); end
      checks++; if (tx_req !== 1'b1)   begin failures++; $display("FAIL gap_ack_tx_req got=%b exp=1", tx_req); end
      checks++; if (tx_byte !== 8'h52) begin failures++; $display("FAIL gap_ack_tx_byte got=%h exp=52", tx_byte); end
      tx_ack = 1'b1;
      @(negedge Clk);
      tx_ack = 1'b0;
      @(negedge Clk);
      checks++; if (level !== 5'd0)    begin failures++; $display("FAIL spur_final_level got=%0d exp=0", level); end
   endtask

   task automatic test_burst_overflow();
      model_reset();
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         @(negedge Clk);
         if (i == 14) begin
            checks++; if (full !== 1'b0)  begin failures++; $display("FAIL burst15_full got=%b exp=0", full); end
            checks++; if (level !== 5'd15) begin failures++; $display("FAIL burst15_level got=%0d exp=15", level); end
         end
      end
      checks++; if (full !== 1'b1)     begin failures++; $display("FAIL burst16_full got=%b exp=1", full); end
      checks++; if (level !== 5'd16)   begin failures++; $display("FAIL burst16_level got=%0d exp=16", level); end
      checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL burst_head got=%h exp=00", tx_byte); end
      wr_data = 8'hEE;
      @(negedge Clk);
      wr_en = 1'b0;
      checks++; if (level !== 5'd16)   begin failures++; $display("FAIL ovf_level got=%0d exp=16", level); end
      checks++; if (ovf !== OVF_ON)    begin failures++; $display("FAIL ovf_set got=%b exp=%b", ovf, OVF_ON); end
      @(negedge Clk);
      checks++; if (ovf !== OVF_ON)    begin failures++; $display("FAIL ovf_sticky got=%b exp=%b", ovf, OVF_ON); end
      wr_en = 1'b1; ovf_clr = 1'b1;
      @(negedge Clk);
      wr_en = 1'b0;
      checks++; if (ovf !== OVF_ON)    begin failures++; $display("FAIL ovf_set_wins got=%b exp=%b", ovf, OVF_ON); end
      @(negedge Clk);
      ovf_clr = 1'b0;
      checks++; if (ovf !== 1'b0)      begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
      uart_drain(16, 5000);
      repeat (UART_BUSY + 5) @(negedge Clk);
      checks++; if (rx_q.size() !== 16) begin failures++; $display("FAIL burst_rx_count got=%0d exp=16", rx_q.size()); end
      for (int i = 0; i < rx_q.size(); i++) begin
         checks++; if (rx_q[i] !== 8'(i)) begin failures++; $display("FAIL burst_rx_byte%0d got=%h exp=%h", i, rx_q[i], 8'(i)); end
      end
      checks++; if (gap_err !== 0)     begin failures++; $display("FAIL burst_gap got=%0d errors exp=0", gap_err); end
      checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL burst_end_empty got=%b exp=1", empty); end
      checks++; if (tx_req !== 1'b0)   begin failures++; $display("FAIL burst_end_tx_req got=%b exp=0", tx_req); end
   endtask

   task automatic test_wrap();
      bit acking;
      int pushed  = 8;
      int lvl_err = 0;
      int cyc     = 0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h80 + i);
         @(negedge Clk);
      end
      wr_en = 1'b0;
      while (pushed < 40 && cyc < 10000) begin
         if (level !== 5'd8) lvl_err++;
         model_step(acking);
         if (acking) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + pushed);
            pushed++;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge Clk);
         cyc++;
      end
      wr_en = 1'b0;
      uart_drain(40, 5000);
      checks++; if (pushed !== 40)      begin failures++; $display("FAIL wrap_pushed got=%0d exp=40", pushed); end
      checks++; if (lvl_err !== 0)      begin failures++; $display("FAIL wrap_level_stable got=%0d errors exp=0", lvl_err); end
      checks++; if (rx_q.size() !== 40) begin failures++; $display("FAIL wrap_rx_count got=%0d exp=40", rx_q.size()); end
      for (int i = 0; i < rx_q.size(); i++) begin
         checks++; if (rx_q[i] !== 8'(8'h80 + i)) begin failures++; $display("FAIL wrap_rx_byte%0d got=%h exp=%h", i, rx_q[i], 8'(8'h80 + i)); end
      end
      checks++; if (gap_err !== 0)      begin failures++; $display("FAIL wrap_gap got=%0d errors exp=0", gap_err); end
      checks++; if (level !== 5'd0)     begin failures++; $display("FAIL wrap_end_level got=%0d exp=0", level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_spurious();
      test_burst_overflow();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
